lsu_ram_master: RTL and testbench

LSU_RAM_MASTER -- requirements
Module: lsu_ram_master

---
 rtl/lsu_ram_master_if.sv | 21 ++
 rtl/lsu_ram_master.sv | 152 +++++++++++++++
 tb/tb_lsu_ram_master.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ram_master_if.sv
// CPU load/store handshake plus the single-port RAM bus driven by lsu_ram_master.
// master = the LSU itself, slave = the CPU/RAM environment around it.
interface lsu_ram_master_if #(parameter int DEPTH = 20);
  logic             req, we, w, h, b, z;
  logic [31:0]      addr, wdata;
  logic             ack, addr_err, busy;
  logic [31:0]      rdata;
  logic             ram_ena, ram_wena;
  logic [DEPTH-1:0] ram_addr;
  logic [31:0]      ram_wdata, ram_rdata;

  modport master (
    input  req, we, w, h, b, z, addr, wdata, ram_rdata,
    output ack, rdata, addr_err, busy, ram_ena, ram_wena, ram_addr, ram_wdata
  );

  modport slave (
    output req, we, w, h, b, z, addr, wdata, ram_rdata,
    input  ack, rdata, addr_err, busy, ram_ena, ram_wena, ram_addr, ram_wdata
  );
endinterface

// File: rtl/lsu_ram_master.sv
// Byte/half/word load-store unit over a 32-bit word RAM with async read.
// Partial stores are read-modify-write: RD captures the word, WR writes it back merged.

// One byte lane of the store merge: keeps the old byte or takes the new one.
module lsu_byte_lane #(parameter int IDX = 0) (
  input  logic [1:0] size,     // 0 byte, 1 half, 2 word
  input  logic [1:0] lane,
  input  logic [7:0] w_byte,   // wdata byte for a word store
  input  logic [7:0] h_byte,   // wdata byte for a half store
  input  logic [7:0] b_byte,   // wdata[7:0]
  input  logic [7:0] old_byte,
  output logic [7:0] new_byte
);
  localparam logic [1:0] LI = IDX[1:0];

  always_comb begin
    new_byte = old_byte;
    case (size)
      2'd0:    if (lane == LI) new_byte = b_byte;
      2'd1:    if (lane[1] == LI[1]) new_byte = h_byte;
      default: new_byte = w_byte;
    endcase
  end
endmodule

module lsu_ram_master #(parameter int DEPTH = 20) (
  input logic clk,
  input logic rst,
  lsu_ram_master_if.master bus
);
  localparam int         NUM_LANES = 4;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

  typedef enum logic [2:0] {IDLE, RD, WR, ACK, ERR} state_t;
  state_t state, nxt;

  logic                             l_we, l_z;
  logic [1:0]                       l_size, l_lane;
  logic [DEPTH-1:0]                 l_idx;
  logic [NUM_LANES-1:0][7:0]        l_wdata, cap, merged, rd_b;
  logic [31:0]                      rdata_q, ld_val;
  logic [1:0]                       in_size;
  logic                             in_mis;
  logic [15:0]                      hv;
  logic [7:0]                       bv;
  logic                             unused_addr_hi;

  assign unused_addr_hi = ^bus.addr[31:DEPTH+2];
  assign rd_b = bus.ram_rdata;

  always_comb begin
    in_size = SZ_W;
    if (bus.w)      in_size = SZ_W;
    else if (bus.h) in_size = SZ_H;
    else if (bus.b) in_size = SZ_B;
    in_mis = ((in_size == SZ_W) && (bus.addr[1:0] != 2'b00)) ||
             ((in_size == SZ_H) && bus.addr[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (bus.req) begin
        if (in_mis)                 nxt = ERR;
        else if (!bus.we)           nxt = RD;
        else if (in_size == SZ_W)   nxt = WR;
        else                        nxt = RD;
      end
      RD:      nxt = l_we ? WR : ACK;
      WR:      nxt = ACK;
      ACK:     nxt = IDLE;
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Load extension from the live RAM word while in RD; registered into rdata at the RD edge
  always_comb begin
    hv     = l_lane[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
    bv     = rd_b[l_lane];
    ld_val = bus.ram_rdata;
    case (l_size)
      SZ_H:    ld_val = {{16{l_z & hv[15]}}, hv};
      SZ_B:    ld_val = {{24{l_z & bv[7]}}, bv};
      default: ld_val = bus.ram_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_we    <= 1'b0;
      l_z     <= 1'b0;
      l_size  <= SZ_W;
      l_lane  <= 2'b00;
      l_idx   <= '0;
      l_wdata <= '0;
      cap     <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && bus.req) begin
        l_we    <= bus.we;
        l_z     <= bus.z;
        l_size  <= in_size;
        l_lane  <= bus.addr[1:0];
        l_idx   <= bus.addr[DEPTH+1:2];
        l_wdata <= bus.wdata;
      end
      if (state == RD) begin
        cap <= bus.ram_rdata;
        if (!l_we) rdata_q <= ld_val;
      end
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_byte_lane #(.IDX(i)) u_lane (
      .size     (l_size),
      .lane     (l_lane),
      .w_byte   (l_wdata[i]),
      .h_byte   (l_wdata[i % 2]),
      .b_byte   (l_wdata[0]),
      .old_byte (cap[i]),
      .new_byte (merged[i])
    );
  end

  // rst gates the outputs combinationally so an access caught mid-flight never writes
  always_comb begin
    bus.ack       = 1'b0;
    bus.addr_err  = 1'b0;
    bus.busy      = 1'b0;
    bus.ram_ena   = 1'b0;
    bus.ram_wena  = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.rdata     = rdata_q;
    if (!rst) begin
      bus.busy     = (state != IDLE);
      bus.ack      = (state == ACK) || (state == ERR);
      bus.addr_err = (state == ERR);
      bus.ram_ena  = (state == RD) || (state == WR);
      bus.ram_wena = (state == WR);
      bus.ram_addr = l_idx;
      if (state == WR) bus.ram_wdata = merged;
    end
  end
endmodule

// File: tb/tb_lsu_ram_master.sv
// Scoreboard bench for lsu_ram_master: a shadow memory predicts load data,
// store results, ack timing and error flags; the monitor pops on every ack.
module tb_lsu_ram_master;
  localparam int DEPTH = 8;
  localparam int WORDS = 2 ** DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_ram_master_if #(.DEPTH(DEPTH)) bus ();
  lsu_ram_master #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];
  int cyc = 0, wr_cnt = 0, ena_cnt = 0;
  int tot = 0, bad = 0;
  logic [31:0] model_rd = '0;

  typedef struct {logic err; logic [31:0] rd; int due;} exp_t;
  exp_t sb[$];

  assign bus.ram_rdata = mem[bus.ram_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.ram_ena && bus.ram_wena) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.ram_ena) ena_cnt <= ena_cnt + 1;
    if (bus.ack) begin
      if (sb.size() == 0) chk("extra_ack", {31'd0, bus.ack}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("ack_cyc", cyc, e.due);
        chk("addr_err", {31'd0, bus.addr_err}, {31'd0, e.err});
        chk("rdata", bus.rdata, e.rd);
      end
    end
  end

  function automatic logic [1:0] msz(input logic w, input logic h, input logic b);
    if (w) return 2'd2;
    if (h) return 2'd1;
    if (b) return 2'd0;
    return 2'd2;
  endfunction

  function automatic logic [31:0] mload(input logic [31:0] wd, input logic [1:0] s,
                                        input logic [1:0] a, input logic z);
    logic [31:0] v;
    if (s == 2'd2) return wd;
    if (s == 2'd1) begin
      v = (wd >> (a[1] ? 16 : 0)) & 32'h0000FFFF;
      if (z && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = (wd >> (8 * a)) & 32'h000000FF;
      if (z && v[7]) v = v | 32'hFFFFFF00;
    end
    return v;
  endfunction

  function automatic logic [31:0] mstore(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [1:0] s, input logic [1:0] a);
    logic [31:0] m;
    if (s == 2'd2) return wd;
    if (s == 2'd1) m = 32'h0000FFFF << (a[1] ? 16 : 0);
    else           m = 32'h000000FF << (8 * a);
    return (old & ~m) | ((wd << (s == 2'd1 ? (a[1] ? 16 : 0) : 8 * a)) & m);
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge following the ack.
  task automatic access(input logic we, input logic w, input logic h, input logic b,
                        input logic z, input logic [31:0] addr, input logic [31:0] wd);
    logic [1:0] s;
    logic err;
    logic [DEPTH-1:0] idx;
    int lat, w0, e0;
    exp_t e;
    s   = msz(w, h, b);
    err = (s == 2'd2 && addr[1:0] != 2'b00) || (s == 2'd1 && addr[0]);
    idx = addr[DEPTH+1:2];
    lat = err ? 1 : (!we ? 2 : (s == 2'd2 ? 2 : 3));
    if (!err && !we) model_rd = mload(ref_mem[idx], s, addr[1:0], z);
    if (!err && we)  ref_mem[idx] = mstore(ref_mem[idx], wd, s, addr[1:0]);
    w0 = wr_cnt; e0 = ena_cnt;
    e.err = err; e.rd = model_rd; e.due = cyc + lat;
    sb.push_back(e);
    bus.we = we; bus.w = w; bus.h = h; bus.b = b; bus.z = z;
    bus.addr = addr; bus.wdata = wd; bus.req = 1'b1;
    @(posedge clk); #1 bus.req = 1'b0;
    for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("ack_timeout", sb.size(), 0);
      sb.delete();
    end
    chk("wr_count", wr_cnt - w0, (we && !err) ? 1 : 0);
    if (err) chk("err_ram_ena", ena_cnt - e0, 0);
    chk("mem_word", mem[idx], ref_mem[idx]);
    @(posedge clk); #1;
  endtask

  initial begin
    int w0;
    logic [31:0] ra;
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    logic [31:0] ra;
    bus.req = 0; bus.we = 0; bus.w = 0; bus.h = 0; bus.b = 0; bus.z = 0;
    bus.addr = '0; bus.wdata = '0;
    for (int i = 0; i < WORDS; i++) mem[i] = (i * 32'h01010101) ^ 32'hA5C3_5A3C;
    mem[4] = 32'h8899AABB;
    mem[5] = 32'h11223344;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = mem[i];

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {31'd0, bus.ack}, 0);
    chk("rst_err", {31'd0, bus.addr_err}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_ena", {31'd0, bus.ram_ena}, 0);
    chk("rst_wena", {31'd0, bus.ram_wena}, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_raddr", {24'd0, bus.ram_addr}, 0);
    chk("rst_wdata", bus.ram_wdata, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    access(0, 0, 0, 1, 1, 32'h12, 0);
    chk("lb_sext", bus.rdata, 32'hFFFFFF99);
    access(0, 0, 0, 1, 0, 32'h12, 0);
    chk("lb_zext", bus.rdata, 32'h00000099);
    access(1, 0, 0, 1, 0, 32'h11, 32'h12345677);
    chk("sb_word", mem[4], 32'h889977BB);
    access(1, 1, 0, 0, 0, 32'h10, 32'h8899AABB);
    access(1, 0, 1, 0, 0, 32'h12, 32'h0000BEEF);
    chk("sh_word", mem[4], 32'hBEEFAABB);
    access(0, 0, 1, 0, 1, 32'h12, 0);
    chk("lh_sext", bus.rdata, 32'hFFFFBEEF);
    access(0, 0, 1, 0, 0, 32'h10, 0);
    access(0, 1, 0, 0, 0, 32'h6, 0);
    access(1, 0, 1, 0, 0, 32'h3, 32'h1234);
    access(0, 1, 1, 1, 1, 32'h10, 0);
    access(0, 0, 1, 1, 0, 32'h11, 0);
    access(0, 0, 0, 0, 0, 32'h14, 0);
    access(0, 1, 0, 0, 0, 32'hABCD_0410, 0);
    access(1, 0, 0, 1, 0, 32'hFFFF_FC07, 32'hFFFF_FF5E);
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      access($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1), ra, $urandom);
    end

    // rst during the WR of a word store
    w0 = wr_cnt;
    bus.we = 1; bus.w = 1; bus.h = 0; bus.b = 0; bus.addr = 32'h8;
    bus.wdata = 32'hDEADBEEF; bus.req = 1;
    @(posedge clk); #1 bus.req = 0; rst = 1;
    @(negedge clk);
    chk("abort_sw_ena", {31'd0, bus.ram_ena}, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort_sw_busy", {31'd0, bus.busy}, 0);
    chk("abort_sw_wr", wr_cnt - w0, 0);
    chk("abort_sw_mem", mem[2], ref_mem[2]);
    @(posedge clk); #1;

    // rst during the RD of a byte store
    w0 = wr_cnt;
    bus.we = 1; bus.w = 0; bus.h = 0; bus.b = 1; bus.addr = 32'h11;
    bus.wdata = 32'h55; bus.req = 1;
    @(posedge clk); #1 bus.req = 0; rst = 1;
    @(posedge clk); #1 rst = 0;
    repeat (4) @(negedge clk);
    chk("abort_sb_busy", {31'd0, bus.busy}, 0);
    chk("abort_sb_wr", wr_cnt - w0, 0);
    chk("abort_sb_mem", mem[4], ref_mem[4]);
    @(posedge clk); #1;

    // rst and req in the same cycle
    bus.we = 0; bus.w = 1; bus.b = 0; bus.addr = 32'h10; bus.req = 1; rst = 1;
    @(posedge clk); #1 bus.req = 0; rst = 0;
    @(negedge clk);
    chk("rst_req_busy", {31'd0, bus.busy}, 0);
    repeat (3) @(posedge clk); #1;

    // req held high: second access sampled in the IDLE after ACK, addr changed meanwhile
    begin
      exp_t e1, e2;
      e1.err = 0; e1.rd = ref_mem[4]; e1.due = cyc + 2;
      e2.err = 0; e2.rd = ref_mem[5]; e2.due = cyc + 5;
      model_rd = ref_mem[5];
      sb.push_back(e1); sb.push_back(e2);
      bus.we = 0; bus.w = 1; bus.h = 0; bus.b = 0; bus.addr = 32'h10; bus.req = 1;
      @(posedge clk); #1 bus.addr = 32'h14;
      repeat (3) @(posedge clk);
      #1 bus.req = 0;
      for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
        chk("b2b_timeout", sb.size(), 0);
        sb.delete();
      end
      repeat (6) @(negedge clk);
      chk("b2b_busy", {31'd0, bus.busy}, 0);
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
